// File: rtl/exe_stage_fwd_if.sv
`default_nettype none
// ============================================================================
// Module   : exe_stage_fwd_if
// Purpose  : Bundles the ID/EX inputs, the EX/MEM and MEM/WB forwarding taps,
//            and the EX/MEM + HI/LO outputs of the execute stage.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Modports
//   master : the driving side (ID/EX register, later stages, observers)
//   slave  : the execute stage itself
// Signal groups
//   ID/EX    : IN_VALID ALU_CTL RS RT RS_VAL RT_VAL IMM SHAMT ALUSRC
//              RD WE MEMREAD MEMWRITE MEMTOREG
//   Forward  : MEM_WE MEM_RD MEM_DATA WB_WE WB_RD WB_DATA
//   Control  : FLUSH (in), STALL (out)
//   EX/MEM   : EX_VALID EX_RESULT EX_STORE EX_RD
//              EX_WE EX_MEMREAD EX_MEMWRITE EX_MEMTOREG
//   Engine   : HI LO
// ============================================================================
interface exe_stage_fwd_if #(
  parameter int W  = 32,
  parameter int RB = 5,
  parameter int SB = 5
);
  // ID/EX register contents
  logic          IN_VALID;
  logic [3:0]    ALU_CTL;
  logic [RB-1:0] RS;
  logic [RB-1:0] RT;
  logic [W-1:0]  RS_VAL;
  logic [W-1:0]  RT_VAL;
  logic [W-1:0]  IMM;
  logic [SB-1:0] SHAMT;
  logic          ALUSRC;
  logic [RB-1:0] RD;
  logic          WE;
  logic          MEMREAD;
  logic          MEMWRITE;
  logic          MEMTOREG;

  // Writeback taps from the later stages
  logic          MEM_WE;
  logic [RB-1:0] MEM_RD;
  logic [W-1:0]  MEM_DATA;
  logic          WB_WE;
  logic [RB-1:0] WB_RD;
  logic [W-1:0]  WB_DATA;

  // Pipeline control
  logic          FLUSH;
  logic          STALL;

  // EX/MEM register contents
  logic          EX_VALID;
  logic [W-1:0]  EX_RESULT;
  logic [W-1:0]  EX_STORE;
  logic [RB-1:0] EX_RD;
  logic          EX_WE;
  logic          EX_MEMREAD;
  logic          EX_MEMWRITE;
  logic          EX_MEMTOREG;

  // Multiply/divide result registers
  logic [W-1:0]  HI;
  logic [W-1:0]  LO;

  modport master (
    output IN_VALID, ALU_CTL, RS, RT, RS_VAL, RT_VAL, IMM, SHAMT, ALUSRC,
           RD, WE, MEMREAD, MEMWRITE, MEMTOREG,
           MEM_WE, MEM_RD, MEM_DATA, WB_WE, WB_RD, WB_DATA, FLUSH,
    input  STALL, EX_VALID, EX_RESULT, EX_STORE, EX_RD,
           EX_WE, EX_MEMREAD, EX_MEMWRITE, EX_MEMTOREG, HI, LO
  );

  modport slave (
    input  IN_VALID, ALU_CTL, RS, RT, RS_VAL, RT_VAL, IMM, SHAMT, ALUSRC,
           RD, WE, MEMREAD, MEMWRITE, MEMTOREG,
           MEM_WE, MEM_RD, MEM_DATA, WB_WE, WB_RD, WB_DATA, FLUSH,
    output STALL, EX_VALID, EX_RESULT, EX_STORE, EX_RD,
           EX_WE, EX_MEMREAD, EX_MEMWRITE, EX_MEMTOREG, HI, LO
  );
endinterface
`default_nettype wire

// File: rtl/exe_stage_fwd.sv
`default_nettype none
// ============================================================================
// Module   : exe_stage_fwd
// Purpose  : In-order pipeline execute stage. Resolves operands through
//            MEM/WB forwarding, evaluates a 16-op ALU, registers the EX/MEM
//            boundary, and runs an iterative unsigned multiply/divide engine
//            that owns HI/LO and stalls the front end while it works.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK    : clock, rising edge
//   RESET  : asynchronous, active-low reset
//   ex_if  : exe_stage_fwd_if.slave - ID/EX inputs, forwarding taps, FLUSH,
//            STALL, EX/MEM register outputs and HI/LO
// Parameters
//   W  : datapath width (even, >= 8)
//   RB : register index width (register 0 reads as zero, never forwarded)
//   SB : shift amount width, equal to log2(W); also sizes the engine counter
// ============================================================================
module exe_stage_fwd #(
  parameter int W  = 32,
  parameter int RB = 5,
  parameter int SB = 5
) (
  input wire          CLK,
  input wire          RESET,
  exe_stage_fwd_if.slave ex_if
);

  // Operation codes
  localparam logic [3:0] C_OP_ADD   = 4'd0;
  localparam logic [3:0] C_OP_SUB   = 4'd1;
  localparam logic [3:0] C_OP_AND   = 4'd2;
  localparam logic [3:0] C_OP_OR    = 4'd3;
  localparam logic [3:0] C_OP_XOR   = 4'd4;
  localparam logic [3:0] C_OP_NOR   = 4'd5;
  localparam logic [3:0] C_OP_SLT   = 4'd6;
  localparam logic [3:0] C_OP_SLTU  = 4'd7;
  localparam logic [3:0] C_OP_SLL   = 4'd8;
  localparam logic [3:0] C_OP_SRL   = 4'd9;
  localparam logic [3:0] C_OP_SRA   = 4'd10;
  localparam logic [3:0] C_OP_LUI   = 4'd11;
  localparam logic [3:0] C_OP_MULTU = 4'd12;
  localparam logic [3:0] C_OP_DIVU  = 4'd13;
  localparam logic [3:0] C_OP_MFHI  = 4'd14;
  localparam logic [3:0] C_OP_MFLO  = 4'd15;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Operand forwarding: the younger EX/MEM result wins over MEM/WB, and
  // register 0 is never forwarded because it is hardwired to zero.
  // --------------------------------------------------------------------------
  function automatic logic [W-1:0] fwd_sel(
    input logic [RB-1:0] idx,
    input logic [W-1:0]  rf_val,
    input logic          mem_we,
    input logic [RB-1:0] mem_rd,
    input logic [W-1:0]  mem_data,
    input logic          wb_we,
    input logic [RB-1:0] wb_rd,
    input logic [W-1:0]  wb_data
  );
    logic [W-1:0] sel;
    sel = rf_val;
    if (idx != '0) begin
      if (mem_we && (mem_rd == idx)) begin
        sel = mem_data;
      end else if (wb_we && (wb_rd == idx)) begin
        sel = wb_data;
      end
    end
    return sel;
  endfunction

  logic [W-1:0] w_op_a;
  logic [W-1:0] w_rt_fwd;
  logic [W-1:0] w_op_b;

  always_comb begin
    w_op_a   = fwd_sel(ex_if.RS, ex_if.RS_VAL, ex_if.MEM_WE, ex_if.MEM_RD,
                       ex_if.MEM_DATA, ex_if.WB_WE, ex_if.WB_RD, ex_if.WB_DATA);
    w_rt_fwd = fwd_sel(ex_if.RT, ex_if.RT_VAL, ex_if.MEM_WE, ex_if.MEM_RD,
                       ex_if.MEM_DATA, ex_if.WB_WE, ex_if.WB_RD, ex_if.WB_DATA);
    w_op_b   = ex_if.ALUSRC ? ex_if.IMM : w_rt_fwd;
  end

  // --------------------------------------------------------------------------
  // State declarations
  // --------------------------------------------------------------------------
  state_t        state_q, state_d;
  logic [SB-1:0] cnt_q, cnt_d;
  logic          is_div_q, is_div_d;
  // Multiply: work_hi = partial product, work_lo = multiplier shifting out.
  // Divide:   work_hi = partial remainder, work_lo = dividend/quotient.
  logic [W-1:0]  work_hi_q, work_hi_d;
  logic [W-1:0]  work_lo_q, work_lo_d;
  // Multiplicand for MULTU, divisor for DIVU.
  logic [W-1:0]  opnd_q, opnd_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;

  logic          ex_valid_q, ex_valid_d;
  logic [W-1:0]  ex_result_q, ex_result_d;
  logic [W-1:0]  ex_store_q, ex_store_d;
  logic [RB-1:0] ex_rd_q, ex_rd_d;
  logic          ex_we_q, ex_we_d;
  logic          ex_memread_q, ex_memread_d;
  logic          ex_memwrite_q, ex_memwrite_d;
  logic          ex_memtoreg_q, ex_memtoreg_d;

  logic w_stall;
  logic w_accept;
  logic w_is_eng_op;
  logic w_launch;

  always_comb begin
    w_stall     = (state_q == S_RUN);
    w_accept    = ex_if.IN_VALID && !w_stall;
    w_is_eng_op = (ex_if.ALU_CTL == C_OP_MULTU) || (ex_if.ALU_CTL == C_OP_DIVU);
    // A flushed MULTU/DIVU is dead and must leave HI/LO untouched.
    w_launch    = w_accept && !ex_if.FLUSH && w_is_eng_op;
  end

  // --------------------------------------------------------------------------
  // Single-cycle ALU
  // --------------------------------------------------------------------------
  logic [W-1:0] w_alu;

  always_comb begin
    w_alu = '0;
    case (ex_if.ALU_CTL)
      C_OP_ADD:   w_alu = w_op_a + w_op_b;
      C_OP_SUB:   w_alu = w_op_a - w_op_b;
      C_OP_AND:   w_alu = w_op_a & w_op_b;
      C_OP_OR:    w_alu = w_op_a | w_op_b;
      C_OP_XOR:   w_alu = w_op_a ^ w_op_b;
      C_OP_NOR:   w_alu = ~(w_op_a | w_op_b);
      C_OP_SLT:   w_alu = {{(W-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
      C_OP_SLTU:  w_alu = {{(W-1){1'b0}}, (w_op_a < w_op_b)};
      C_OP_SLL:   w_alu = w_op_b << ex_if.SHAMT;
      C_OP_SRL:   w_alu = w_op_b >> ex_if.SHAMT;
      C_OP_SRA:   w_alu = $unsigned($signed(w_op_b) >>> ex_if.SHAMT);
      C_OP_LUI:   w_alu = w_op_b << (W/2);
      // Engine launches produce no register result.
      C_OP_MULTU: w_alu = '0;
      C_OP_DIVU:  w_alu = '0;
      C_OP_MFHI:  w_alu = hi_q;
      C_OP_MFLO:  w_alu = lo_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // EX/MEM register next state. Anything not accepted becomes a bubble.
  // --------------------------------------------------------------------------
  always_comb begin
    ex_valid_d    = 1'b0;
    ex_result_d   = '0;
    ex_store_d    = '0;
    ex_rd_d       = '0;
    ex_we_d       = 1'b0;
    ex_memread_d  = 1'b0;
    ex_memwrite_d = 1'b0;
    ex_memtoreg_d = 1'b0;
    if (w_accept) begin
      ex_valid_d    = !ex_if.FLUSH;
      ex_result_d   = w_alu;
      ex_store_d    = w_rt_fwd;
      ex_rd_d       = ex_if.RD;
      // MULTU/DIVU write HI/LO, never the register file.
      ex_we_d       = ex_if.WE && !w_is_eng_op;
      ex_memread_d  = ex_if.MEMREAD;
      ex_memwrite_d = ex_if.MEMWRITE;
      ex_memtoreg_d = ex_if.MEMTOREG;
    end
  end

  // --------------------------------------------------------------------------
  // Engine datapath: one shift-add or restoring-divide step per cycle.
  // --------------------------------------------------------------------------
  logic [W:0]   w_mul_sum;
  logic [W:0]   w_div_shift;
  logic [W-1:0] w_div_diff;
  logic         w_div_ge;
  logic [W-1:0] w_step_hi;
  logic [W-1:0] w_step_lo;

  always_comb begin
    w_mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opnd_q} : '0);
    // Bring the next dividend bit into the partial remainder.
    w_div_shift = {work_hi_q, work_lo_q[W-1]};
    w_div_ge    = (w_div_shift >= {1'b0, opnd_q});
    // Only used when the trial fits, so the true difference is below 2^W.
    w_div_diff  = w_div_shift[W-1:0] - opnd_q;
    if (is_div_q) begin
      w_step_hi = w_div_ge ? w_div_diff : w_div_shift[W-1:0];
      w_step_lo = {work_lo_q[W-2:0], w_div_ge};
    end else begin
      w_step_hi = w_mul_sum[W:1];
      w_step_lo = {w_mul_sum[0], work_lo_q[W-1:1]};
    end
  end

  // --------------------------------------------------------------------------
  // Engine FSM next state. A zero divisor needs no special case: every trial
  // subtraction succeeds, giving an all-ones quotient and remainder = A.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    work_hi_d = work_hi_q;
    work_lo_d = work_lo_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      S_IDLE: begin
        if (w_launch) begin
          state_d   = S_RUN;
          cnt_d     = SB'(W - 1);
          is_div_d  = (ex_if.ALU_CTL == C_OP_DIVU);
          work_hi_d = '0;
          if (ex_if.ALU_CTL == C_OP_DIVU) begin
            work_lo_d = w_op_a;
            opnd_d    = w_op_b;
          end else begin
            work_lo_d = w_op_b;
            opnd_d    = w_op_a;
          end
        end
      end
      S_RUN: begin
        work_hi_d = w_step_hi;
        work_lo_d = w_step_lo;
        if (cnt_q == '0) begin
          // HI/LO are published only on the final step.
          state_d = S_IDLE;
          hi_d    = w_step_hi;
          lo_d    = w_step_lo;
        end else begin
          cnt_d = cnt_q - SB'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      work_hi_q <= '0;
      work_lo_q <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      work_hi_q <= work_hi_d;
      work_lo_q <= work_lo_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ex_valid_q    <= 1'b0;
      ex_result_q   <= '0;
      ex_store_q    <= '0;
      ex_rd_q       <= '0;
      ex_we_q       <= 1'b0;
      ex_memread_q  <= 1'b0;
      ex_memwrite_q <= 1'b0;
      ex_memtoreg_q <= 1'b0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_result_q   <= ex_result_d;
      ex_store_q    <= ex_store_d;
      ex_rd_q       <= ex_rd_d;
      ex_we_q       <= ex_we_d;
      ex_memread_q  <= ex_memread_d;
      ex_memwrite_q <= ex_memwrite_d;
      ex_memtoreg_q <= ex_memtoreg_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign ex_if.STALL       = w_stall;
  assign ex_if.EX_VALID    = ex_valid_q;
  assign ex_if.EX_RESULT   = ex_result_q;
  assign ex_if.EX_STORE    = ex_store_q;
  assign ex_if.EX_RD       = ex_rd_q;
  assign ex_if.EX_WE       = ex_we_q;
  assign ex_if.EX_MEMREAD  = ex_memread_q;
  assign ex_if.EX_MEMWRITE = ex_memwrite_q;
  assign ex_if.EX_MEMTOREG = ex_memtoreg_q;
  assign ex_if.HI          = hi_q;
  assign ex_if.LO          = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_exe_stage_fwd.sv
`default_nettype none
// ============================================================================
// Module   : tb_exe_stage_fwd
// Purpose  : Self-checking bench for exe_stage_fwd. Directed scenarios with
//            literal expectations, then randomized traffic compared every
//            cycle against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exe_stage_fwd;
  localparam int W  = 32;
  localparam int RB = 5;
  localparam int SB = 5;

  logic CLK = 1'b0;
  logic RESET;

  always #5 CLK = ~CLK;

  exe_stage_fwd_if #(.W(W), .RB(RB), .SB(SB)) ex_if ();

  exe_stage_fwd #(.W(W), .RB(RB), .SB(SB)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .ex_if (ex_if)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  int          m_busy;              // stall cycles still to come, this cycle included
  logic [31:0] m_hi, m_lo, m_pend_hi, m_pend_lo;
  logic        e_valid, e_we, e_mr, e_mw, e_mtr;
  logic        e_chk_ctl, e_chk_data, e_chk_res;
  logic [31:0] e_res, e_store;
  logic [4:0]  e_rd;

  function automatic logic [31:0] m_fwd(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 5'd0) return rf;
    if (ex_if.MEM_WE && ex_if.MEM_RD == idx) return ex_if.MEM_DATA;
    if (ex_if.WB_WE && ex_if.WB_RD == idx) return ex_if.WB_DATA;
    return rf;
  endfunction

  function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [4:0] sh);
    int sb;
    sb = b;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~(a | b);
      4'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7:  return (a < b) ? 32'd1 : 32'd0;
      4'd8:  return b << sh;
      4'd9:  return b >> sh;
      4'd10: return 32'(sb >>> sh);
      4'd11: return b << 16;
      4'd14: return m_hi;
      4'd15: return m_lo;
      default: return 32'd0;
    endcase
  endfunction

  // Compare current outputs, then advance the model across the coming edge.
  always @(negedge CLK) begin
    logic        acc;
    logic        eng;
    logic [3:0]  op;
    logic [31:0] a, b, rtf;
    logic [63:0] p;
    if (!RESET) begin
      m_busy = 0; m_hi = '0; m_lo = '0;
      e_valid = 0; e_we = 0; e_mr = 0; e_mw = 0; e_mtr = 0;
      e_chk_ctl = 1; e_chk_data = 0; e_chk_res = 0;
    end else begin
      chk("STALL", ex_if.STALL, (m_busy > 0));
      chk("EX_VALID", ex_if.EX_VALID, e_valid);
      chk("HI", ex_if.HI, m_hi);
      chk("LO", ex_if.LO, m_lo);
      if (e_chk_ctl)
        chk("EX_CTL", {ex_if.EX_WE, ex_if.EX_MEMREAD, ex_if.EX_MEMWRITE, ex_if.EX_MEMTOREG},
            {e_we, e_mr, e_mw, e_mtr});
      if (e_chk_data) begin
        chk("EX_RD", ex_if.EX_RD, e_rd);
        chk("EX_STORE", ex_if.EX_STORE, e_store);
        if (e_chk_res) chk("EX_RESULT", ex_if.EX_RESULT, e_res);
      end
    end

    op  = ex_if.ALU_CTL;
    eng = (op == 4'd12) || (op == 4'd13);
    acc = ex_if.IN_VALID && (m_busy == 0);
    rtf = m_fwd(ex_if.RT, ex_if.RT_VAL);
    a   = m_fwd(ex_if.RS, ex_if.RS_VAL);
    b   = ex_if.ALUSRC ? ex_if.IMM : rtf;
    if (acc) begin
      e_valid    = !ex_if.FLUSH;
      e_chk_data = 1;
      e_chk_res  = !eng;
      e_res      = m_alu(op, a, b, ex_if.SHAMT);
      e_store    = rtf;
      e_rd       = ex_if.RD;
      e_chk_ctl  = !ex_if.FLUSH;
      e_we       = ex_if.WE && !eng;
      e_mr       = ex_if.MEMREAD;
      e_mw       = ex_if.MEMWRITE;
      e_mtr      = ex_if.MEMTOREG;
    end else begin
      e_valid = 0; e_we = 0; e_mr = 0; e_mw = 0; e_mtr = 0;
      e_chk_ctl = 1; e_chk_data = 0; e_chk_res = 0;
    end
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_hi = m_pend_hi;
        m_lo = m_pend_lo;
      end
    end
    if (acc && !ex_if.FLUSH && eng) begin
      m_busy = W;
      if (op == 4'd12) begin
        p = 64'(a) * 64'(b);
        m_pend_hi = p[63:32];
        m_pend_lo = p[31:0];
      end else if (b == 32'd0) begin
        m_pend_hi = a;
        m_pend_lo = 32'hFFFF_FFFF;
      end else begin
        m_pend_hi = a % b;
        m_pend_lo = a / b;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic idle_inputs();
    ex_if.IN_VALID = 0; ex_if.ALU_CTL = 0; ex_if.RS = 0; ex_if.RT = 0;
    ex_if.RS_VAL = 0; ex_if.RT_VAL = 0; ex_if.IMM = 0; ex_if.SHAMT = 0;
    ex_if.ALUSRC = 0; ex_if.RD = 0; ex_if.WE = 0; ex_if.MEMREAD = 0;
    ex_if.MEMWRITE = 0; ex_if.MEMTOREG = 0; ex_if.MEM_WE = 0; ex_if.MEM_RD = 0;
    ex_if.MEM_DATA = 0; ex_if.WB_WE = 0; ex_if.WB_RD = 0; ex_if.WB_DATA = 0;
    ex_if.FLUSH = 0;
  endtask

  task automatic instr(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [31:0] rsv, input logic [31:0] rtv, input logic [4:0] rd);
    idle_inputs();
    ex_if.IN_VALID = 1; ex_if.ALU_CTL = op; ex_if.RS = rs; ex_if.RT = rt;
    ex_if.RS_VAL = rsv; ex_if.RT_VAL = rtv; ex_if.RD = rd; ex_if.WE = 1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_engine(output int n);
    n = 0;
    while (ex_if.STALL && n < 200) begin
      n++;
      tick();
    end
  endtask

  function automatic logic [31:0] rval();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(0, 20));
      3: return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    int n;
    logic [3:0] op;
    RESET = 0;
    idle_inputs();
    repeat (3) tick();
    chk("reset STALL", ex_if.STALL, 0);
    chk("reset EX_VALID", ex_if.EX_VALID, 0);
    chk("reset EX_RESULT", ex_if.EX_RESULT, 0);
    chk("reset HI", ex_if.HI, 0);
    chk("reset LO", ex_if.LO, 0);
    @(negedge CLK); #1; RESET = 1;
    tick();

    // ADD with MEM forwarding on RS
    instr(4'd0, 5'd1, 5'd2, 32'd5, 32'd7, 5'd3);
    ex_if.MEM_WE = 1; ex_if.MEM_RD = 5'd1; ex_if.MEM_DATA = 32'd100;
    tick();
    chk("ADD fwd result", ex_if.EX_RESULT, 107);
    chk("ADD valid", ex_if.EX_VALID, 1);
    chk("ADD rd", ex_if.EX_RD, 3);

    // SUB with MEM and WB both targeting RT: MEM wins
    instr(4'd1, 5'd1, 5'd2, 32'd20, 32'd50, 5'd3);
    ex_if.MEM_WE = 1; ex_if.MEM_RD = 5'd2; ex_if.MEM_DATA = 32'd9;
    ex_if.WB_WE = 1; ex_if.WB_RD = 5'd2; ex_if.WB_DATA = 32'd4;
    tick();
    chk("SUB prio result", ex_if.EX_RESULT, 11);

    // RT = 0 is never forwarded
    instr(4'd0, 5'd1, 5'd0, 32'd20, 32'd3, 5'd3);
    ex_if.MEM_WE = 1; ex_if.MEM_RD = 5'd0; ex_if.MEM_DATA = 32'd99;
    ex_if.WB_WE = 1; ex_if.WB_RD = 5'd0; ex_if.WB_DATA = 32'd77;
    tick();
    chk("r0 result", ex_if.EX_RESULT, 23);
    chk("r0 store", ex_if.EX_STORE, 3);

    // MULTU max x max, with MFHI held behind it
    instr(4'd12, 5'd1, 5'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    tick();
    chk("MULTU EX_WE", ex_if.EX_WE, 0);
    chk("MULTU valid", ex_if.EX_VALID, 1);
    instr(4'd14, 5'd0, 5'd0, 32'd0, 32'd0, 5'd4);
    wait_engine(n);
    chk("MULTU stall cycles", n, 32);
    chk("MULTU HI", ex_if.HI, 32'hFFFF_FFFE);
    chk("MULTU LO", ex_if.LO, 32'h0000_0001);
    tick();
    chk("MFHI result", ex_if.EX_RESULT, 32'hFFFF_FFFE);
    chk("MFHI valid", ex_if.EX_VALID, 1);

    // DIVU 100 / 7
    instr(4'd13, 5'd1, 5'd2, 32'd100, 32'd7, 5'd0);
    tick();
    idle_inputs();
    wait_engine(n);
    chk("DIVU LO", ex_if.LO, 14);
    chk("DIVU HI", ex_if.HI, 2);

    // DIVU 55 / 0
    instr(4'd13, 5'd1, 5'd2, 32'd55, 32'd0, 5'd0);
    tick();
    idle_inputs();
    wait_engine(n);
    chk("DIVU0 LO", ex_if.LO, 32'hFFFF_FFFF);
    chk("DIVU0 HI", ex_if.HI, 55);

    // Flushed DIVU does not launch
    instr(4'd13, 5'd1, 5'd2, 32'd9, 32'd3, 5'd0);
    ex_if.FLUSH = 1;
    tick();
    idle_inputs();
    chk("flush STALL", ex_if.STALL, 0);
    chk("flush EX_VALID", ex_if.EX_VALID, 0);
    tick();
    chk("flush HI", ex_if.HI, 55);
    chk("flush LO", ex_if.LO, 32'hFFFF_FFFF);

    // Reset mid-RUN
    instr(4'd12, 5'd1, 5'd2, 32'd1234, 32'd5678, 5'd0);
    tick();
    idle_inputs();
    repeat (9) tick();
    chk("RUN cycle 10 STALL", ex_if.STALL, 1);
    RESET = 0;
    #1;
    chk("async rst STALL", ex_if.STALL, 0);
    chk("async rst HI", ex_if.HI, 0);
    chk("async rst LO", ex_if.LO, 0);
    chk("async rst EX_VALID", ex_if.EX_VALID, 0);
    chk("async rst EX_RESULT", ex_if.EX_RESULT, 0);
    @(negedge CLK); #1; RESET = 1;
    tick();

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 4) op = ($urandom_range(0, 1) != 0) ? 4'd13 : 4'd12;
      else begin
        op = 4'($urandom_range(0, 13));
        if (op >= 4'd12) op = op + 4'd2;
      end
      ex_if.IN_VALID = ($urandom_range(0, 99) < 85);
      ex_if.ALU_CTL  = op;
      ex_if.RS       = 5'($urandom_range(0, 3));
      ex_if.RT       = 5'($urandom_range(0, 3));
      ex_if.RS_VAL   = rval();
      ex_if.RT_VAL   = rval();
      ex_if.IMM      = rval();
      ex_if.SHAMT    = 5'($urandom_range(0, 31));
      ex_if.ALUSRC   = 1'($urandom_range(0, 1));
      ex_if.RD       = 5'($urandom_range(0, 31));
      ex_if.WE       = 1'($urandom_range(0, 1));
      ex_if.MEMREAD  = 1'($urandom_range(0, 1));
      ex_if.MEMWRITE = 1'($urandom_range(0, 1));
      ex_if.MEMTOREG = 1'($urandom_range(0, 1));
      ex_if.MEM_WE   = 1'($urandom_range(0, 1));
      ex_if.MEM_RD   = 5'($urandom_range(0, 3));
      ex_if.MEM_DATA = rval();
      ex_if.WB_WE    = 1'($urandom_range(0, 1));
      ex_if.WB_RD    = 5'($urandom_range(0, 3));
      ex_if.WB_DATA  = rval();
      ex_if.FLUSH    = ($urandom_range(0, 9) == 0);
      tick();
    end
    idle_inputs();
    wait_engine(n);
    repeat (2) tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/exe_stage_fwd.md
# exe_stage_fwd

Parametrised execute stage for the in-order pipeline, sitting between the ID/EX and EX/MEM boundaries. It adds MEM/WB operand forwarding, a registered EX/MEM output with valid/flush control, and an iterative unsigned multiply/divide engine with HI/LO registers. While that engine runs, it stalls the front end.

## Interface
- W, 32, datapath width; even, ≥ 8
- RB, 5, register-index width; register 0 is hardwired zero
- SB, 5, shift-amount width; must equal log2(W)
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- IN_VALID  in  1  ID/EX holds a valid instruction
- ALU_CTL  in  4  operation code (see Operation)
- RS, RT  in  RB each  source register indices
- RS_VAL, RT_VAL  in  W each  register-file values; write-through is ID's responsibility
- IMM  in  W  immediate, already extended by ID
- SHAMT  in  SB  shift amount
- ALUSRC  in  1  operand B = IMM when 1, forwarded RT value when 0
- RD, WE, MEMREAD, MEMWRITE, MEMTOREG  in  RB/1/1/1/1  destination and control, passed through
- MEM_WE, MEM_RD, MEM_DATA  in  1/RB/W  EX/MEM-stage writeback info
- WB_WE, WB_RD, WB_DATA  in  1/RB/W  MEM/WB-stage writeback info
- FLUSH  in  1  synchronous kill of the instruction entering EX/MEM
- STALL  out  1  EX is not accepting; ID/EX must hold
- EX_VALID, EX_RESULT, EX_STORE, EX_RD  out  1/W/W/RB  EX/MEM register contents
- EX_WE, EX_MEMREAD, EX_MEMWRITE, EX_MEMTOREG  out  1 each  EX/MEM control
- HI, LO  out  W each  multiply/divide result registers

## Operation
- Forwarding is evaluated per operand (RS→A, RT→B-source):
  - If MEM_WE and MEM_RD == idx and idx ≠ 0, use MEM_DATA.
  - Else if WB_WE and WB_RD == idx and idx ≠ 0, use WB_DATA.
  - Else use the register-file value.
  - MEM has priority over WB.
- Operand B is IMM when ALUSRC = 1. EX_STORE always carries the forwarded RT value.
- ALU_CTL codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR: modulo 2^W, no overflow trap.
  - 6 SLT (signed), 7 SLTU: result is 1 or 0, zero-extended.
  - 8 SLL, 9 SRL, 10 SRA: shift B by SHAMT.
  - 11 LUI: B << (W/2).
  - 12 MULTU, 13 DIVU: launch the engine; EX_WE is forced to 0.
  - 14 MFHI, 15 MFLO: result = HI or LO.
- An instruction is accepted when IN_VALID && !STALL. Accepting loads the EX/MEM register with EX_VALID = !FLUSH.
  - If IN_VALID && STALL, or !IN_VALID, a bubble is loaded: EX_VALID = 0 and all control outputs are 0.
- Engine states: IDLE → RUN (W cycles, counter W−1 down to 0) → IDLE.
  - It is launched only by an accepted, non-flushed MULTU/DIVU.
- MULTU: shift-add algorithm. Final {HI, LO} = A × B, a 2W-bit unsigned product.
- DIVU: restoring division. LO = A / B, HI = A mod B.
  - If B == 0: LO = all ones, HI = A.
- HI/LO change only on the final RUN edge.
- STALL = (state == RUN). MFHI/MFLO therefore always read settled HI/LO.
- FLUSH never aborts a running engine.

## Timing
- Reset: all outputs are 0, HI = LO = 0, engine is IDLE, STALL = 0.
- Reset asserted mid-RUN aborts the operation and leaves HI = LO = 0.
- Single-cycle ops: EX/MEM outputs update at the edge that ends the accept cycle, so latency is 1.
- Forwarding is purely combinational within the accept cycle.
- Engine timing, with MULTU/DIVU accepted in cycle t:
  - STALL is high in cycles t+1 … t+W.
  - HI/LO update at the end of cycle t+W.
  - The next instruction is accepted no earlier than cycle t+W+1.
- During STALL: the held instruction re-evaluates forwarding every cycle, and the EX/MEM register receives bubbles.
- FLUSH and an accept in the same cycle: EX_VALID = 0, and no engine launch even for MULTU/DIVU.

## Test plan
- ADD r3 = r1 + r2, with RS_VAL = 5, RT_VAL = 7, and MEM_WE = 1, MEM_RD = 1, MEM_DATA = 100 → EX_RESULT = 107 one cycle later.
- Both MEM and WB target r2 (MEM_DATA = 9, WB_DATA = 4), SUB with A = 20 → 11. RT = 0 with MEM_RD = 0 → the register value is used.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF (W = 32) → STALL high for exactly 32 cycles; HI = 0xFFFFFFFE, LO = 0x00000001; then MFHI returns 0xFFFFFFFE.
- DIVU 100 / 7 → LO = 14, HI = 2. DIVU 55 / 0 → LO = 0xFFFFFFFF, HI = 55.
- DIVU accepted with FLUSH = 1 → no stall, HI/LO unchanged, EX_VALID = 0.
- RESET pulsed low at RUN cycle 10 → STALL = 0, HI = LO = 0, and all EX outputs 0 immediately (asynchronously, before the next clock edge).
